// File: rtl/aes_display_sequencer.sv
// Shows a 128-bit AES block on an 8-digit 7-segment display as four rotating 32-bit pages.
// Digit scan and page rotation use single-cycle enable strobes derived from clk.
module aes_display_sequencer #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned PAGE_DIV = 500000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] data_in,
    input  logic         data_valid,
    output logic         data_ready,
    input  logic         next_page,
    input  logic         loop_en,
    output logic [7:0]   an,
    output logic [6:0]   seg,
    output logic         dp,
    output logic [1:0]   page_idx,
    output logic         busy,
    output logic         page_wrap
);

    typedef enum logic [0:0] {StIdle, StShow} state_e;

    state_e       state_q, state_d;
    logic         ready_q;
    logic [31:0]  scan_cnt_q, scan_cnt_d;
    logic [2:0]   digit_q, digit_d;
    logic [31:0]  page_cnt_q, page_cnt_d;
    logic [1:0]   page_idx_q, page_idx_d;
    logic         page_wrap_q, page_wrap_d;
    logic [127:0] block_q, block_d;
    logic [7:0]   an_q, an_d;
    logic [6:0]   seg_q, seg_d;
    logic         dp_q, dp_d;

    logic         scan_tick;
    logic         page_tick;
    logic         transfer;
    logic [31:0]  page_word;
    logic [3:0]   nibble;

    assign transfer  = data_valid & ready_q;
    assign scan_tick = (scan_cnt_q == SCAN_DIV - 1);
    assign page_tick = (state_q == StShow) && (page_cnt_q == PAGE_DIV - 1);

    always_comb begin
        scan_cnt_d = scan_cnt_q + 32'd1;
        digit_d    = digit_q;
        if (scan_tick) begin
            scan_cnt_d = 32'd0;
            digit_d    = digit_q + 3'd1;
        end
    end

    // Priority: transfer > next_page > page_tick; next_page and page_tick together advance once.
    always_comb begin
        state_d     = state_q;
        page_cnt_d  = page_cnt_q;
        page_idx_d  = page_idx_q;
        page_wrap_d = 1'b0;
        block_d     = block_q;
        if (transfer) begin
            block_d    = data_in;
            page_idx_d = 2'd0;
            page_cnt_d = 32'd0;
            state_d    = StShow;
        end else if (state_q == StShow) begin
            if (next_page || page_tick) begin
                page_cnt_d = 32'd0;
                if (page_idx_q != 2'd3) begin
                    page_idx_d = page_idx_q + 2'd1;
                end else begin
                    page_wrap_d = 1'b1;
                    page_idx_d  = 2'd0;
                    if (!loop_en) begin
                        state_d = StIdle;
                    end
                end
            end else begin
                page_cnt_d = page_cnt_q + 32'd1;
            end
        end
    end

    always_comb begin
        unique case (page_idx_q)
            2'd0:    page_word = block_q[127:96];
            2'd1:    page_word = block_q[95:64];
            2'd2:    page_word = block_q[63:32];
            default: page_word = block_q[31:0];
        endcase
    end

    assign nibble = page_word[{digit_q, 2'b00} +: 4];

    always_comb begin
        an_d  = 8'hFF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (state_q == StShow) begin
            an_d = ~(8'd1 << digit_q);
            dp_d = (digit_q != {1'b0, page_idx_q});
            case (nibble)
                4'h0:    seg_d = 7'b1000000;
                4'h1:    seg_d = 7'b1111001;
                4'h2:    seg_d = 7'b0100100;
                4'h3:    seg_d = 7'b0110000;
                4'h4:    seg_d = 7'b0011001;
                4'h5:    seg_d = 7'b0010010;
                4'h6:    seg_d = 7'b0000010;
                4'h7:    seg_d = 7'b1111000;
                4'h8:    seg_d = 7'b0000000;
                4'h9:    seg_d = 7'b0010000;
                4'hA:    seg_d = 7'b0001000;
                4'hB:    seg_d = 7'b0000011;
                4'hC:    seg_d = 7'b1000110;
                4'hD:    seg_d = 7'b0100001;
                4'hE:    seg_d = 7'b0000110;
                default: seg_d = 7'b0001110;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ready_q     <= 1'b0;
            scan_cnt_q  <= 32'd0;
            digit_q     <= 3'd0;
            page_cnt_q  <= 32'd0;
            page_idx_q  <= 2'd0;
            page_wrap_q <= 1'b0;
            an_q        <= 8'hFF;
            seg_q       <= 7'h7F;
            dp_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            ready_q     <= 1'b1;
            scan_cnt_q  <= scan_cnt_d;
            digit_q     <= digit_d;
            page_cnt_q  <= page_cnt_d;
            page_idx_q  <= page_idx_d;
            page_wrap_q <= page_wrap_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    // The held block survives reset so the last result can be redisplayed.
    always_ff @(posedge clk) begin
        block_q <= block_d;
    end

    assign data_ready = ready_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign page_idx   = page_idx_q;
    assign busy       = (state_q == StShow);
    assign page_wrap  = page_wrap_q;

endmodule

// File: tb/tb_aes_display_sequencer.sv
// Self-checking bench for aes_display_sequencer with SCAN_DIV=4, PAGE_DIV=64.
module tb_aes_display_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] data_in;
    logic         data_valid;
    logic         data_ready;
    logic         next_page;
    logic         loop_en;
    logic [7:0]   an;
    logic [6:0]   seg;
    logic         dp;
    logic [1:0]   page_idx;
    logic         busy;
    logic         page_wrap;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] Blk1 = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [127:0] Blk2 = 128'h9B1C6400_00000000_00000000_00000000;
    localparam logic [127:0] Blk3 = 128'h00000000_00000000_00000D2F_00000000;
    localparam logic [127:0] BlkF = {128{1'b1}};

    aes_display_sequencer #(
        .SCAN_DIV(4),
        .PAGE_DIV(64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .data_valid(data_valid),
        .data_ready(data_ready),
        .next_page (next_page),
        .loop_en   (loop_en),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .page_idx  (page_idx),
        .busy      (busy),
        .page_wrap (page_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] blk;
        int unsigned  page;
        int unsigned  digit;
        logic [6:0]   seg;
        logic         dp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [127:0] blk);
        data_in    = blk;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    // Bounded wait until the given digit is lit; returns 1 if seen.
    task automatic wait_digit(input int unsigned d, output logic found);
        logic [7:0] exp_an;
        exp_an = ~(8'd1 << d);
        found  = 1'b0;
        for (int w = 0; w < 40; w++) begin
            if (an == exp_an) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic found;
        int   wraps;
        int   first_wrap;
        int   last_wrap;
        int   bad;

        vecs[0]  = '{Blk1, 0, 7, 7'b1000000, 1'b1};
        vecs[1]  = '{Blk1, 0, 0, 7'b1111000, 1'b0};
        vecs[2]  = '{Blk1, 1, 7, 7'b0000000, 1'b1};
        vecs[3]  = '{Blk1, 1, 1, 7'b0000110, 1'b0};
        vecs[4]  = '{Blk1, 2, 2, 7'b0001000, 1'b0};
        vecs[5]  = '{Blk1, 2, 6, 7'b0000110, 1'b1};
        vecs[6]  = '{Blk1, 3, 3, 7'b0110000, 1'b0};
        vecs[7]  = '{Blk1, 3, 5, 7'b0010010, 1'b1};
        vecs[8]  = '{Blk2, 0, 6, 7'b0000011, 1'b1};
        vecs[9]  = '{Blk2, 0, 3, 7'b0000010, 1'b1};
        vecs[10] = '{Blk2, 0, 2, 7'b0011001, 1'b1};
        vecs[11] = '{Blk3, 2, 2, 7'b0100001, 1'b0};

        rst        = 1'b1;
        data_in    = '0;
        data_valid = 1'b0;
        next_page  = 1'b0;
        loop_en    = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_ready", 32'(data_ready), 32'd0);
        chk("rst_an", 32'(an), 32'hFF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_page", 32'(page_idx), 32'd0);
        chk("rst_wrap", 32'(page_wrap), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(data_ready), 32'd1);
        chk("idle_an", 32'(an), 32'hFF);

        // First cycle in SHOW is still blank, the next one is lit.
        send(Blk1);
        chk("show_busy", 32'(busy), 32'd1);
        chk("first_cycle_blank", 32'(an), 32'hFF);
        @(negedge clk);
        chk("second_cycle_lit", 32'(an != 8'hFF), 32'd1);

        for (int i = 0; i < 12; i++) begin
            send(vecs[i].blk);
            for (int p = 0; p < int'(vecs[i].page); p++) begin
                next_page = 1'b1;
                @(negedge clk);
                next_page = 1'b0;
            end
            @(negedge clk);
            wait_digit(vecs[i].digit, found);
            chk($sformatf("vec%0d_digit_seen", i), 32'(found), 32'd1);
            chk($sformatf("vec%0d_seg", i), 32'(seg), 32'(vecs[i].seg));
            chk($sformatf("vec%0d_dp", i), 32'(dp), 32'(vecs[i].dp));
            chk($sformatf("vec%0d_page", i), 32'(page_idx), vecs[i].page);
        end

        // Looping rotation: wraps every 256 cycles, busy never drops.
        loop_en = 1'b1;
        send(Blk1);
        wraps = 0; first_wrap = -1; last_wrap = -1; bad = 0;
        for (int k = 0; k <= 520; k++) begin
            if (page_wrap) begin
                wraps++;
                if (first_wrap < 0) first_wrap = k;
                last_wrap = k;
            end
            if (!busy) bad++;
            if (k == 0)   chk("loop_p_k0", 32'(page_idx), 32'd0);
            if (k == 63)  chk("loop_p_k63", 32'(page_idx), 32'd0);
            if (k == 64)  chk("loop_p_k64", 32'(page_idx), 32'd1);
            if (k == 128) chk("loop_p_k128", 32'(page_idx), 32'd2);
            if (k == 192) chk("loop_p_k192", 32'(page_idx), 32'd3);
            if (k == 256) chk("loop_p_k256", 32'(page_idx), 32'd0);
            if (k == 320) chk("loop_p_k320", 32'(page_idx), 32'd1);
            @(negedge clk);
        end
        chk("loop_wraps", 32'(wraps), 32'd2);
        chk("loop_first_wrap", 32'(first_wrap), 32'd256);
        chk("loop_last_wrap", 32'(last_wrap), 32'd512);
        chk("loop_busy_drops", 32'(bad), 32'd0);

        // next_page mid-page, then next_page coinciding with page_tick on page 3.
        send(Blk1);
        for (int k = 0; k <= 266; k++) begin
            if (k == 73)  chk("np_before", 32'(page_idx), 32'd1);
            if (k == 74)  chk("np_advance", 32'(page_idx), 32'd2);
            if (k == 137) chk("np_p2_full_end", 32'(page_idx), 32'd2);
            if (k == 138) chk("np_p3_start", 32'(page_idx), 32'd3);
            if (k == 202) chk("np_tick_once", 32'(page_idx), 32'd0);
            if (k == 202) chk("np_tick_wrap", 32'(page_wrap), 32'd1);
            if (k == 203) chk("np_wrap_pulse", 32'(page_wrap), 32'd0);
            if (k == 265) chk("np_p0_full", 32'(page_idx), 32'd0);
            if (k == 266) chk("np_p0_end", 32'(page_idx), 32'd1);
            next_page = (k == 73 || k == 201);
            @(negedge clk);
        end
        next_page = 1'b0;

        // Transfer during page 2, together with next_page: transfer wins.
        send(Blk1);
        wraps = 0; bad = 0;
        for (int k = 0; k <= 205; k++) begin
            if (page_wrap) wraps++;
            if (k == 140) chk("xfer_before", 32'(page_idx), 32'd2);
            if (k == 141) chk("xfer_page0", 32'(page_idx), 32'd0);
            if (k == 141) chk("xfer_busy", 32'(busy), 32'd1);
            if (k >= 142 && k <= 173 && (seg != 7'b0001110 || an == 8'hFF)) bad++;
            if (k == 204) chk("xfer_p0_full", 32'(page_idx), 32'd0);
            if (k == 205) chk("xfer_p0_end", 32'(page_idx), 32'd1);
            data_valid = (k == 140);
            next_page  = (k == 140);
            data_in    = BlkF;
            @(negedge clk);
        end
        data_valid = 1'b0;
        next_page  = 1'b0;
        chk("xfer_no_wrap", 32'(wraps), 32'd0);
        chk("xfer_all_f", 32'(bad), 32'd0);

        // Single pass: page 3 expiry returns to IDLE.
        loop_en = 1'b0;
        send(Blk1);
        wraps = 0;
        for (int k = 0; k <= 262; k++) begin
            if (page_wrap) wraps++;
            if (k == 64)  chk("once_p_k64", 32'(page_idx), 32'd1);
            if (k == 191) chk("once_p_k191", 32'(page_idx), 32'd2);
            if (k == 192) chk("once_p_k192", 32'(page_idx), 32'd3);
            if (k == 255) chk("once_busy_k255", 32'(busy), 32'd1);
            if (k == 256) chk("once_wrap", 32'(page_wrap), 32'd1);
            if (k == 256) chk("once_idle", 32'(busy), 32'd0);
            if (k == 256) chk("once_page0", 32'(page_idx), 32'd0);
            if (k == 257) chk("once_an_blank", 32'(an), 32'hFF);
            if (k == 257) chk("once_seg_blank", 32'(seg), 32'h7F);
            if (k == 257) chk("once_dp_blank", 32'(dp), 32'd1);
            @(negedge clk);
        end
        chk("once_wrap_count", 32'(wraps), 32'd1);

        // next_page in IDLE is ignored.
        next_page = 1'b1;
        @(negedge clk);
        next_page = 1'b0;
        @(negedge clk);
        chk("idle_np_busy", 32'(busy), 32'd0);
        chk("idle_np_page", 32'(page_idx), 32'd0);
        chk("idle_np_an", 32'(an), 32'hFF);

        // Reset mid-SHOW, then a fresh transfer.
        send(Blk1);
        for (int k = 0; k <= 102; k++) begin
            if (k == 100) chk("mid_rst_busy_pre", 32'(busy), 32'd1);
            if (k == 101) begin
                chk("mid_rst_busy", 32'(busy), 32'd0);
                chk("mid_rst_an", 32'(an), 32'hFF);
                chk("mid_rst_seg", 32'(seg), 32'h7F);
                chk("mid_rst_dp", 32'(dp), 32'd1);
                chk("mid_rst_page", 32'(page_idx), 32'd0);
                chk("mid_rst_ready", 32'(data_ready), 32'd0);
                chk("mid_rst_wrap", 32'(page_wrap), 32'd0);
            end
            if (k == 102) chk("mid_rst_ready_back", 32'(data_ready), 32'd1);
            rst = (k == 100);
            if (k < 102) @(negedge clk);
        end
        rst = 1'b0;
        send(Blk1);
        @(negedge clk);
        wait_digit(7, found);
        chk("post_rst_digit_seen", 32'(found), 32'd1);
        chk("post_rst_seg", 32'(seg), 32'(7'b1000000));
        chk("post_rst_busy", 32'(busy), 32'd1);
        chk("post_rst_page", 32'(page_idx), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_display_sequencer.md
Name: aes_display_sequencer

Overview:
Shows a 128-bit AES result (ciphertext or key) on the board's 8-digit 7-segment display. The block accepts a block over a valid/ready handshake and splits it into four 32-bit pages of 8 hex digits each. Digits are time-multiplexed at the scan rate, and pages rotate at the page interval (5 s by default). Timing uses internal single-cycle enable strobes derived from the system clock, not generated clocks. The block sits between the AES core output and the board display pins.

Parameters:
SCAN_DIV, 100000, clk cycles per digit slot (1 kHz digit rate at 100 MHz).
PAGE_DIV, 500000000, clk cycles per page (5 s at 100 MHz); must be < 2^32.

Ports:
clk  input  1  system clock, all logic on posedge.
rst  input  1  synchronous active-high reset.
data_in  input  128  block to display; bit 127 is the most significant.
data_valid  input  1  data_in is valid this cycle.
data_ready  output  1  block can accept data_in.
next_page  input  1  single-cycle pulse (pre-debounced) that advances the page immediately.
loop_en  input  1  1 = wrap from page 3 back to 0; 0 = go IDLE after page 3.
an  output  8  digit anodes, active-low one-hot; an[7] is the leftmost digit.
seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
dp  output  1  decimal point, active-low.
page_idx  output  2  page currently shown.
busy  output  1  1 while in SHOW.
page_wrap  output  1  one-cycle pulse when page 3 expires.

Behaviour:
- Clocking and reset
  - Single clock domain.
  - On a rst cycle, outputs take these values at the next edge: an=8'hFF, seg=7'h7F, dp=1, page_idx=0, busy=0, page_wrap=0, data_ready=0.
  - State goes to IDLE and all counters clear.
  - The held block register is not cleared.
  - Reset mid-SHOW aborts the display at the next edge.
- data_ready
  - Registered. It is 1 from the first cycle after rst deasserts and stays 1 in both IDLE and SHOW.
  - A transfer occurs on a cycle where data_valid & data_ready is true.
- Scan counter
  - Counts 0..SCAN_DIV-1 and runs continuously after reset.
  - At terminal count it emits scan_tick and digit index d (3 bits) increments, wrapping 7 -> 0.
- State machine: IDLE, SHOW.
  - IDLE: display blank (an=8'hFF, seg=7'h7F, dp=1), busy=0. A transfer latches data_in, sets page_idx=0, clears the page counter, and moves to SHOW.
  - SHOW: busy=1. The page counter counts 0..PAGE_DIV-1.
- Page counter terminal count (page_tick)
  - If page_idx<3: page_idx increments.
  - If page_idx==3: page_wrap pulses. With loop_en=1, page_idx goes to 0 and the block stays in SHOW. With loop_en=0, the block goes to IDLE and page_idx goes to 0.
- next_page in SHOW
  - Same effect as a page_tick, including the wrap/IDLE rule and the page_wrap pulse on page 3.
  - Also clears the page counter.
  - next_page in IDLE is ignored.
- Simultaneous events, priority: transfer > next_page > page_tick.
  - A transfer in SHOW restarts at page 0 with the new block and a cleared page counter. No page_wrap pulse is issued on that cycle.
  - next_page coinciding with page_tick advances exactly one page.
- Digit mapping
  - Page p shows block bits [127-32p -: 32].
  - Digit d shows nibble [4d+3:4d] of that word, so digit 7 shows the most significant nibble.
- Outputs in SHOW
  - an = ~(1<<d).
  - seg = active-low hex pattern: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - dp=0 only when d==page_idx; this marks which page is shown.
- Latency
  - an, seg and dp are registered and reflect d, page_idx and the block with 1 cycle of latency.
  - The first lit digit appears 1 cycle after entering SHOW.
- Width rules
  - Counters are 32-bit unsigned and compare against parameter-1.
  - No overflow is possible for legal parameters.

Test Plan:
All runs use SCAN_DIV=4 and PAGE_DIV=64.
- Reset release → data_ready=0 during reset, 1 on the next cycle; an=8'hFF, seg=7'h7F; busy=0.
- Send data_in=128'h0123456789ABCDEF_FEDCBA9876543210 with loop_en=0 → page 0 shows 01234567 (digit 7 seg=1000000, digit 0 seg=1111000). Pages then show 89ABCDEF, FEDCBA98, 76543210, each lasting 64 cycles. page_wrap pulses once at the end of page 3, then the block returns to IDLE with a blank display.
- Same block with loop_en=1 → page_idx sequence 0,1,2,3,0,1 with page_wrap every 256 cycles; busy stays 1.
- next_page pulse at cycle 10 of page 1 → page_idx=2 at the next edge and page 2 lasts a full 64 cycles. next_page coincident with page_tick → exactly one advance.
- New transfer (all-F block) during page 2 → at the next edge page_idx=0, every digit seg=0001110, and no page_wrap pulse.
- rst asserted mid-SHOW → at the next edge the block is in IDLE with all outputs at reset values. A subsequent transfer displays normally.
